// File: rtl/div_fu.sv
// div_fu - iterative integer divide functional unit (DIV/DIVU/REM/REMU).
//
// Restoring radix-2 divider: one quotient bit per cycle over XLEN cycles,
// followed by a single fix-up cycle that applies sign correction and the
// divide-by-zero / signed-overflow results.
//
// Optional build macro: DIV_FAST_SPECIAL_EN
//   When defined, divide-by-zero and signed-overflow operations skip the
//   iterative phase and complete two cycles after issue.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset
//   EN    in   issue strobe; accepted only while busy is low
//   op    in   2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU
//   a     in   dividend (XLEN bits)
//   b     in   divisor (XLEN bits)
//   busy  out  operation in flight
//   done  out  one-cycle pulse when res updates
//   res   out  registered result, held until the next completion
module div_fu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            EN,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);

    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]   cnt;
    logic [1:0]      op_q;
    logic [XLEN-1:0] dvd_q;   // dividend shifts out, quotient shifts in
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] a_q;
    logic            a_neg_q;
    logic            b_neg_q;
    logic            dz_q;
    logic            ovf_q;
    logic [XLEN-1:0] res_q;
    logic            done_q;

    logic            load;
    logic            step;
    logic            finish;

    // Issue-time operand decode
    logic            sgn_in;
    logic            a_neg_in;
    logic            b_neg_in;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            dz_in;
    logic            ovf_in;
    logic [CW-1:0]   cnt_init;

    // Iteration datapath
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            qbit;
    logic [XLEN-1:0] rem_nxt;

    // Fix-up datapath
    logic            q_neg;
    logic            r_neg;
    logic [XLEN-1:0] fix_res;

    always_comb begin
        sgn_in   = ~op[0];
        a_neg_in = sgn_in & a[XLEN-1];
        b_neg_in = sgn_in & b[XLEN-1];
        abs_a    = a_neg_in ? -a : a;
        abs_b    = b_neg_in ? -b : b;
        dz_in    = (b == '0);
        ovf_in   = sgn_in & (a == MIN_NEG) & (b == '1);
`ifdef DIV_FAST_SPECIAL_EN
        // Special cases park in FIX for one extra cycle so done lands two
        // edges after issue.
        cnt_init = (dz_in | ovf_in) ? CW'(1) : CW'(XLEN);
`else
        cnt_init = CW'(XLEN);
`endif
    end

    always_comb begin
        shifted = {rem_q, dvd_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        qbit    = ~diff[XLEN];
        rem_nxt = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

    always_comb begin
        q_neg = ~op_q[0] & (a_neg_q ^ b_neg_q);
        r_neg = ~op_q[0] & a_neg_q;
        if (dz_q) begin
            fix_res = op_q[1] ? a_q : '1;
        end else if (ovf_q) begin
            fix_res = op_q[1] ? '0 : MIN_NEG;
        end else if (op_q[1]) begin
            fix_res = r_neg ? -rem_q : rem_q;
        end else begin
            fix_res = q_neg ? -dvd_q : dvd_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (EN) begin
                    load = 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
                    next_state = (dz_in | ovf_in) ? FIX : CALC;
`else
                    next_state = CALC;
`endif
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == CW'(1)) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                if (cnt == '0) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            op_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            a_q     <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= finish;
            if (load) begin
                cnt     <= cnt_init;
                op_q    <= op;
                dvd_q   <= abs_a;
                dvs_q   <= abs_b;
                rem_q   <= '0;
                a_q     <= a;
                a_neg_q <= a_neg_in;
                b_neg_q <= b_neg_in;
                dz_q    <= dz_in;
                ovf_q   <= ovf_in;
            end else if (step) begin
                rem_q <= rem_nxt;
                dvd_q <= {dvd_q[XLEN-2:0], qbit};
                cnt   <= cnt - CW'(1);
            end else if ((state == FIX) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
            if (finish) begin
                res_q <= fix_res;
            end
        end
    end

    assign done = done_q;
    assign res  = res_q;

endmodule

// File: tb/tb_div_fu.sv
// tb_div_fu - self-checking bench for div_fu (XLEN=32).
// Expected results are queued when an operation is issued and popped when
// done is observed.
module tb_div_fu;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam int NORM_LAT = 33;
`ifdef DIV_FAST_SPECIAL_EN
    localparam int SPECIAL_LAT = 2;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        EN;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] res;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_q[$];

    div_fu #(.XLEN(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .EN   (EN),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .res  (res)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int sx;
        int sy;
        sx = x;
        sy = y;
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : x;
        if (!o[0]) return o[1] ? 32'(sx % sy) : 32'(sx / sy);
        return o[1] ? (x % y) : (x / y);
    endfunction

    function automatic bit special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        return (y == 32'd0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    // Call at a negedge; the following posedge is the issue edge.
    task automatic start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
        EN = 1'b1;
        op = o;
        a  = x;
        b  = y;
        exp_q.push_back(e);
    endtask

    // Follows one issued operation to its done pulse. inject_at > 0 raises a
    // second EN (different operands) at that cycle, which must be ignored.
    task automatic wait_done(input string name, input int exp_lat, input int inject_at);
        int n;
        bit seen;
        logic [31:0] e;
        logic [31:0] prev;
        prev = res;
        @(posedge clk);
        n = 0;
        seen = 0;
        while (n <= 100 && !seen) begin
            @(negedge clk);
            if (n == 0) begin
                EN = 1'b0;
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy_after_issue: got %b expected 1", name, busy);
                end
            end
            if (n == 5 && done !== 1'b1) begin
                n_checks++;
                if (res !== prev) begin
                    n_fail++;
                    $display("FAIL %s res_hold: got %h expected %h", name, res, prev);
                end
            end
            if (inject_at > 0 && n == inject_at) begin
                EN = 1'b1;
                op = OP_DIVU;
                a  = 32'd1000;
                b  = 32'd3;
            end
            if (inject_at > 0 && n == inject_at + 1) EN = 1'b0;
            if (done === 1'b1) seen = 1;
            else n++;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s timeout: no done within 100 cycles, expected at %0d", name, exp_lat);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            if (n != exp_lat) begin
                n_fail++;
                $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
            end
            e = exp_q.pop_front();
            n_checks++;
            if (res !== e) begin
                n_fail++;
                $display("FAIL %s res: got %h expected %h", name, res, e);
            end
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_in_done: got %b expected 0", name, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        EN  = 1'b0;
        op  = 2'b00;
        a   = '0;
        b   = '0;
        repeat (2) @(negedge clk);
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
        if (res !== 32'd0) begin n_fail++; $display("FAIL reset res: got %h expected 0", res); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        start(OP_DIV, 32'd100, 32'd7, 32'd14);
        wait_done("div_100_7", NORM_LAT, 0);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b expected 0", done); end
        start(OP_REM, 32'd100, 32'd7, 32'd2);
        wait_done("rem_100_7", NORM_LAT, 0);
        @(negedge clk);
        start(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        wait_done("rem_m7_2", NORM_LAT, 0);
        @(negedge clk);
        start(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        wait_done("div_m7_2", NORM_LAT, 0);
        @(negedge clk);
        start(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
        wait_done("divu_max_1", NORM_LAT, 0);
        @(negedge clk);
        start(OP_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5);
        wait_done("remu_max_10", NORM_LAT, 0);
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            o = 2'($urandom_range(0, 3));
            x = $urandom();
            y = (i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 300));
            if (i == 5) y = 32'hFFFF_FFFF;
            start(o, x, y, model(o, x, y));
            wait_done("random", special(o, x, y) ? SPECIAL_LAT : NORM_LAT, 0);
        end
    endtask

    task automatic test_div_zero();
        @(negedge clk);
        start(OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        wait_done("div_m5_0", SPECIAL_LAT, 0);
        @(negedge clk);
        start(OP_REMU, 32'd9, 32'd0, 32'd9);
        wait_done("remu_9_0", SPECIAL_LAT, 0);
        @(negedge clk);
        start(OP_REM, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0);
        wait_done("rem_m16_0", SPECIAL_LAT, 0);
        @(negedge clk);
        start(OP_DIVU, 32'd0, 32'd0, 32'hFFFF_FFFF);
        wait_done("divu_0_0", SPECIAL_LAT, 0);
    endtask

    task automatic test_overflow();
        @(negedge clk);
        start(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_done("div_ovf", SPECIAL_LAT, 0);
        @(negedge clk);
        start(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        wait_done("rem_ovf", SPECIAL_LAT, 0);
        @(negedge clk);
        start(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        wait_done("divu_no_ovf", NORM_LAT, 0);
    endtask

    task automatic test_ignore_busy();
        @(negedge clk);
        start(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        wait_done("ignore_busy", NORM_LAT, 10);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy idle_after: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start(OP_DIVU, 32'd1000, 32'd3, 32'd333);
        wait_done("b2b_first", NORM_LAT, 0);
        start(OP_REMU, 32'd1000, 32'd3, 32'd1);
        wait_done("b2b_second", NORM_LAT, 0);
        start(OP_DIV, 32'd50, 32'hFFFF_FFFB, 32'hFFFF_FFF6);
        wait_done("b2b_third", NORM_LAT, 0);
    endtask

    task automatic test_reset_abort();
        bit got_done;
        @(negedge clk);
        start(OP_DIV, 32'd12345, 32'd67, 32'd184);
        void'(exp_q.pop_back());
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) EN = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort done: got %b expected 0", done); end
        if (res !== 32'd0) begin n_fail++; $display("FAIL abort res: got %h expected 0", res); end
        rst = 1'b0;
        got_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) got_done = 1;
        end
        n_checks += 2;
        if (got_done) begin n_fail++; $display("FAIL abort stray_done: got 1 expected 0"); end
        if (res !== 32'd0) begin n_fail++; $display("FAIL abort res_after: got %h expected 0", res); end
        start(OP_DIVU, 32'd20, 32'd3, 32'd6);
        wait_done("after_reset_divu", NORM_LAT, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_overflow();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
